// File: rtl/sms_psg_audio_out_if.sv
// rtl/sms_psg_audio_out_if.sv - PSG mix input, sample output and I2S pins of the PSG audio stage
interface sms_psg_audio_out_if;
  logic [15:0] PSG;
  logic        MUTE;
  logic [15:0] SAMPLE_o;
  logic        SAMPLE_VALID;
  logic        I2S_BCLK;
  logic        I2S_LRCK;
  logic        I2S_DATA;

  // Source side: drives the PSG mix and mute, receives samples and I2S pins
  modport master (
    output PSG,
    output MUTE,
    input  SAMPLE_o,
    input  SAMPLE_VALID,
    input  I2S_BCLK,
    input  I2S_LRCK,
    input  I2S_DATA
  );

  // Audio stage side
  modport slave (
    input  PSG,
    input  MUTE,
    output SAMPLE_o,
    output SAMPLE_VALID,
    output I2S_BCLK,
    output I2S_LRCK,
    output I2S_DATA
  );
endinterface

// File: rtl/sms_psg_audio_out.sv
// rtl/sms_psg_audio_out.sv - PSG box-car decimator, DC blocker and mono-duplicated I2S serializer
module sms_psg_audio_out #(
  parameter int BCLK_HALF = 8,
  parameter int DC_SHIFT  = 10
) (
  input logic                MCLK,
  input logic                RESET,
  sms_psg_audio_out_if.slave bus
);
  localparam int DECIM    = 128 * BCLK_HALF;
  localparam int L        = $clog2(DECIM);
  localparam int BCLK_BIT = $clog2(BCLK_HALF);
  localparam int SLOT_LSB = BCLK_BIT + 1;
  localparam int AW       = 16 + L;

  logic [L-1:0]       fc_q, fc_d;
  logic [AW-1:0]      acc_q, acc_d, acc_sum;
  logic [15:0]        avg_q;
  logic               avg_vld_q;
  logic signed [15:0] x_prev_q, y_prev_q;
  logic signed [15:0] x_c, y_c, y_leak;
  logic signed [18:0] y_wide;
  logic [15:0]        sample_q, tx_q;
  logic               valid_q, bclk_q, lrck_q, data_q;
  logic               data_d, frame_last, frame_first, dc_load;
  logic [4:0]         slot;
  logic [3:0]         bit_idx;

  // Frame timing, decimation sum, DC-blocker arithmetic and serial bit selection
  always_comb begin
    fc_d        = fc_q + L'(1);
    frame_last  = (fc_q == L'(DECIM - 1));
    frame_first = (fc_q == '0);
    acc_sum     = acc_q + AW'(bus.PSG);
    acc_d       = frame_last ? '0 : acc_sum;

    // Unsigned midscale 0x8000 becomes signed zero
    x_c    = {~avg_q[15], avg_q[14:0]};
    y_leak = y_prev_q >>> DC_SHIFT;
    // 19 bits hold the worst case of a full-scale step plus the leaky state
    y_wide = {{3{x_c[15]}}, x_c} - {{3{x_prev_q[15]}}, x_prev_q}
           + {{3{y_prev_q[15]}}, y_prev_q} - {{3{y_leak[15]}}, y_leak};
    if (DC_SHIFT == 0)
      y_c = x_c;
    else if (y_wide > 19'sd32767)
      y_c = 16'sh7FFF;
    else if (y_wide < -19'sd32768)
      y_c = 16'sh8000;
    else
      y_c = y_wide[15:0];

    // Nothing is loaded until one complete window has been averaged
    dc_load = frame_first & avg_vld_q;

    // Slot 0 is the I2S one-bit delay, word occupies slots 1..16 MSB first
    slot    = fc_q[L-2:SLOT_LSB];
    bit_idx = 4'(5'd16 - slot);
    data_d  = 1'b0;
    if (slot >= 5'd1 && slot <= 5'd16)
      data_d = tx_q[bit_idx];
  end

  // State update: counter, accumulator, DC state, output sample, tx word and I2S pins
  always_ff @(posedge MCLK) begin
    if (RESET) begin
      fc_q      <= '0;
      acc_q     <= '0;
      avg_q     <= '0;
      avg_vld_q <= 1'b0;
      x_prev_q  <= '0;
      y_prev_q  <= '0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      tx_q      <= '0;
      bclk_q    <= 1'b0;
      lrck_q    <= 1'b0;
      data_q    <= 1'b0;
    end else begin
      fc_q    <= fc_d;
      acc_q   <= acc_d;
      valid_q <= dc_load;
      bclk_q  <= fc_q[BCLK_BIT];
      lrck_q  <= fc_q[L-1];
      data_q  <= data_d;
      if (frame_last) begin
        avg_q     <= acc_sum[AW-1:L];
        avg_vld_q <= 1'b1;
        tx_q      <= bus.MUTE ? 16'h0000 : sample_q;
      end
      // DC state tracks the input even while muted so unmute is step-free
      if (dc_load) begin
        x_prev_q <= x_c;
        y_prev_q <= y_c;
        sample_q <= bus.MUTE ? 16'h0000 : y_c;
      end
    end
  end

  assign bus.SAMPLE_o     = sample_q;
  assign bus.SAMPLE_VALID = valid_q;
  assign bus.I2S_BCLK     = bclk_q;
  assign bus.I2S_LRCK     = lrck_q;
  assign bus.I2S_DATA     = data_q;
endmodule
